// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and
// sign_mask field constants used by the top and the lane formatter.
// No ports; imported with import dmem_responder_pkg::*.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_READ_BUFFER = 2'd1,
        S_READ        = 2'd2,
        S_WRITE       = 2'd3
    } state_t;

    // sign_mask[2:0] size codes; any other code behaves as a word access
    localparam logic [2:0] SM_BYTE       = 3'b001;
    localparam logic [2:0] SM_HALF       = 3'b011;
    localparam logic [2:0] SM_WORD       = 3'b111;
    localparam int         SM_SIGNED_BIT = 3;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane logic: formats a buffered word for a load and
// merges store data into it. Ports: word_in (buffered RAM word), byte_off
// (addr[1:0]), sign_mask, write_data -> load_val, store_word. No state.
module dmem_lane_fmt
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  byte_off,
    input  logic [3:0]  sign_mask,
    input  logic [31:0] write_data,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic        sgn;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  bit_off;

    always_comb begin
        sgn        = sign_mask[SM_SIGNED_BIT];
        bit_off    = {byte_off, 3'b000};
        byte_sel   = word_in[bit_off +: 8];
        half_sel   = byte_off[1] ? word_in[31:16] : word_in[15:0];
        load_val   = word_in;
        store_word = write_data;
        case (sign_mask[2:0])
            SM_BYTE: begin
                load_val   = {{24{sgn & byte_sel[7]}}, byte_sel};
                store_word = word_in;
                store_word[bit_off +: 8] = write_data[7:0];
            end
            SM_HALF: begin
                // addr[0] is ignored for halfwords: only addr[1] picks the half
                load_val   = {{16{sgn & half_sel[15]}}, half_sel};
                store_word = word_in;
                if (byte_off[1]) store_word[31:16] = write_data[15:0];
                else             store_word[15:0]  = write_data[15:0];
            end
            default: begin
                // SM_WORD and every unsupported code: full-word access
                load_val   = word_in;
                store_word = write_data;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word loads and stores plus
// one LED register at LED_ADDR. Each access stalls the CPU for two cycles
// (IDLE -> READ_BUFFER -> READ/WRITE); clk_stall is high while in flight.
// Ports: clk, reset (sync, active-high), addr, write_data, memwrite, memread,
// sign_mask -> read_data, clk_stall, led.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR  = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic [7:0]  led
);

    localparam int AW = $clog2(DEPTH);

    state_t      state;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_mask;
    logic        a_store;
    logic [31:0] buf_word;

    logic [31:0] mem [DEPTH];

    logic [31:0] offset;
    logic [AW-1:0] word_idx;
    logic        is_led;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        unused_offset_bits;

    // Out-of-range addresses simply wrap modulo DEPTH words
    assign offset             = a_addr - BASE_ADDR;
    assign word_idx           = offset[AW+1:2];
    assign is_led             = (a_addr == LED_ADDR);
    assign unused_offset_bits = &{1'b0, offset[31:AW+2], offset[1:0]};

    dmem_lane_fmt u_lane_fmt (
        .word_in    (buf_word),
        .byte_off   (a_addr[1:0]),
        .sign_mask  (a_mask),
        .write_data (a_wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            clk_stall <= 1'b0;
            read_data <= 32'h0;
            led       <= 8'h0;
            a_addr    <= 32'h0;
            a_wdata   <= 32'h0;
            a_mask    <= 4'h0;
            a_store   <= 1'b0;
            buf_word  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memread || memwrite) begin
                        a_addr    <= addr;
                        a_wdata   <= write_data;
                        a_mask    <= sign_mask;
                        // read+write together is a store
                        a_store   <= memwrite;
                        clk_stall <= 1'b1;
                        state     <= S_READ_BUFFER;
                    end
                end
                S_READ_BUFFER: begin
                    // Stores also read first so sub-word merges keep other lanes
                    buf_word <= mem[word_idx];
                    state    <= a_store ? S_WRITE : S_READ;
                end
                S_READ: begin
                    read_data <= is_led ? {24'h0, led} : load_val;
                    clk_stall <= 1'b0;
                    state     <= S_IDLE;
                end
                S_WRITE: begin
                    if (is_led) led <= a_wdata[7:0];
                    clk_stall <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM has no reset; a reset landing on the WRITE edge drops the store
    always_ff @(posedge clk) begin
        if (!reset && state == S_WRITE && !is_led) begin
            mem[word_idx] <= store_word;
        end
    end

endmodule
